// File: rtl/fp_addsub_seq_if.sv
// Request/response bundle for the sequential FP32 add/sub unit.
//
// Handshake semantics: a request transfers on a rising clk edge where
// in_valid & in_ready are both high (and flush is low); opa/opb/op_sub/rm
// must be stable while in_valid is high. A response transfers on an edge
// where out_valid & out_ready are both high; result/fflags stay constant
// while out_valid is high and out_ready is low. in_ready never depends on
// in_valid, and out_valid never depends on out_ready.
interface fp_addsub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [2:0]  rm;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic        busy;
  logic [2:0]  state_dbg;

  modport master (
    output in_valid, op_sub, rm, opa, opb, flush, out_ready,
    input  in_ready, out_valid, result, fflags, busy, state_dbg
  );

  modport slave (
    input  in_valid, op_sub, rm, opa, opb, flush, out_ready,
    output in_ready, out_valid, result, fflags, busy, state_dbg
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP32 add/sub: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// One operation in flight; result appears five cycles after accept.
module fp_addsub_seq #(
  parameter int MANT_W        = 48,
  parameter bit LATENCY_CHECK = 1'b1
) (
  input logic            clk,
  input logic            reset,
  fp_addsub_seq_if.slave bus
);
  // Working sum layout: [SW-1] carry, [SW-2:1] aligned field, [0] sticky.
  localparam int SW = MANT_W + 2;
  localparam logic [MANT_W-1:0] ONE = 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nx;
  logic   accept;

  // Latched request
  logic [31:0] a_q, b_q;
  logic        sub_q;
  logic [2:0]  rm_q;
  // ALIGN -> ADD
  logic              s1_q, s2_q, stk_q;
  logic [9:0]        exp_q;
  logic [MANT_W-1:0] m1_q, m2_q;
  logic              spec_q, spec_nv_q;
  logic [31:0]       spec_val_q;
  // ADD -> NORM
  logic [SW-1:0]     sum_q;
  logic              sgn_q;
  // NORM -> ROUND
  logic [SW-1:0]     nm_q;
  logic [9:0]        nexp_q;
  // Output
  logic [31:0]       res_q;
  logic [4:0]        flags_q;

  assign accept        = (state == S_IDLE) && bus.in_valid && !bus.flush;
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = res_q;
  assign bus.fflags    = flags_q;
  assign bus.state_dbg = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state: flush kills work in the middle states, not a finished result
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ALIGN;
      S_ALIGN: state_nx = bus.flush ? S_IDLE : S_ADD;
      S_ADD:   state_nx = bus.flush ? S_IDLE : S_NORM;
      S_NORM:  state_nx = bus.flush ? S_IDLE : S_ROUND;
      S_ROUND: state_nx = bus.flush ? S_IDLE : S_DONE;
      S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ALIGN: magnitude swap, alignment shift with sticky, special-case classification
  logic              sa, sb, swap, s_hi, s_lo;
  logic [30:0]       hi_mag, lo_mag;
  logic [7:0]        e_hi, e_lo, d;
  logic [MANT_W-1:0] hi_field, lo_field, m2_al;
  logic              stk_al;
  logic              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic              spec, spec_nv;
  logic [31:0]       spec_val;
  always_comb begin
    sa       = a_q[31];
    sb       = b_q[31] ^ sub_q;
    swap     = (b_q[30:0] > a_q[30:0]);
    hi_mag   = swap ? b_q[30:0] : a_q[30:0];
    lo_mag   = swap ? a_q[30:0] : b_q[30:0];
    s_hi     = swap ? sb : sa;
    s_lo     = swap ? sa : sb;
    e_hi     = (hi_mag[30:23] == 8'd0) ? 8'd1 : hi_mag[30:23];
    e_lo     = (lo_mag[30:23] == 8'd0) ? 8'd1 : lo_mag[30:23];
    d        = e_hi - e_lo;
    hi_field = {(hi_mag[30:23] != 8'd0), hi_mag[22:0], {(MANT_W-24){1'b0}}};
    lo_field = {(lo_mag[30:23] != 8'd0), lo_mag[22:0], {(MANT_W-24){1'b0}}};
    if (int'(d) >= MANT_W) begin
      m2_al  = '0;
      stk_al = |lo_field;
    end else begin
      m2_al  = lo_field >> d;
      stk_al = |(lo_field & ((ONE << d) - ONE));
    end
    a_nan    = (&a_q[30:23]) && (|a_q[22:0]);
    b_nan    = (&b_q[30:23]) && (|b_q[22:0]);
    a_snan   = a_nan && !a_q[22];
    b_snan   = b_nan && !b_q[22];
    a_inf    = (&a_q[30:23]) && (a_q[22:0] == 23'd0);
    b_inf    = (&b_q[30:23]) && (b_q[22:0] == 23'd0);
    spec     = 1'b0;
    spec_nv  = 1'b0;
    spec_val = 32'd0;
    if (a_nan || b_nan) begin
      spec     = 1'b1;
      spec_val = QNAN;
      spec_nv  = a_snan || b_snan;
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec     = 1'b1;
      spec_val = QNAN;
      spec_nv  = 1'b1;
    end else if (a_inf) begin
      spec     = 1'b1;
      spec_val = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec     = 1'b1;
      spec_val = {sb, 8'hFF, 23'd0};
    end
  end

  // ADD: larger minus smaller on opposite signs; exact zero difference is +0 (RDN: -0)
  logic          eff_sub;
  logic [SW-1:0] op1, op2, sum_c;
  logic          sgn_c;
  always_comb begin
    eff_sub = s1_q ^ s2_q;
    op1     = {1'b0, m1_q, 1'b0};
    op2     = {1'b0, m2_q, stk_q};
    sum_c   = eff_sub ? (op1 - op2) : (op1 + op2);
    sgn_c   = s1_q;
    if (eff_sub && (sum_c == '0)) sgn_c = (rm_q == 3'b010);
  end

  function automatic logic [9:0] lzc(input logic [SW-2:0] v);
    lzc = 10'(SW - 1);
    for (int i = 0; i < SW - 1; i++) begin
      if (v[i]) lzc = 10'(SW - 2 - i);
    end
  endfunction

  // NORM: carry shifts right into sticky; otherwise left shift bounded at exp=1
  logic [9:0]    lz, lim, sh;
  logic [SW-1:0] nm_c;
  logic [9:0]    nexp_c;
  always_comb begin
    lz     = lzc(sum_q[SW-2:0]);
    lim    = exp_q - 10'd1;
    sh     = (lz > lim) ? lim : lz;
    nm_c   = sum_q << sh;
    nexp_c = exp_q - sh;
    if (sum_q[SW-1]) begin
      nm_c   = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      nexp_c = exp_q + 10'd1;
    end
  end

  // ROUND: guard/round/sticky rounding, overflow saturation, special override
  logic [23:0] mant, mant_f;
  logic [24:0] mant_r;
  logic        g, lower, inexact, inc, tiny;
  logic [9:0]  exp_f;
  logic [31:0] res_c;
  logic [4:0]  flags_c;
  always_comb begin
    mant    = nm_q[SW-2 -: 24];
    g       = nm_q[SW-26];
    lower   = nm_q[SW-27] | (|nm_q[SW-28:0]);
    inexact = g | lower;
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sgn_q & inexact;
      3'b011:  inc = ~sgn_q & inexact;
      3'b100:  inc = g;
      default: inc = g & (lower | mant[0]);
    endcase
    mant_r = {1'b0, mant} + {24'd0, inc};
    mant_f = mant_r[24] ? mant_r[24:1] : mant_r[23:0];
    exp_f  = mant_r[24] ? (nexp_q + 10'd1) : nexp_q;
    tiny   = !mant_f[23];
    if (exp_f >= 10'd255) begin
      case (rm_q)
        3'b001:  res_c = {sgn_q, 31'h7F7F_FFFF};
        3'b010:  res_c = sgn_q ? {1'b1, 31'h7F80_0000} : 32'h7F7F_FFFF;
        3'b011:  res_c = sgn_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: res_c = {sgn_q, 31'h7F80_0000};
      endcase
      flags_c = 5'b00101;
    end else begin
      res_c   = {sgn_q, (tiny ? 8'd0 : exp_f[7:0]), mant_f[22:0]};
      flags_c = {3'b000, tiny & inexact, inexact};
    end
    if (spec_q) begin
      res_c   = spec_val_q;
      flags_c = {spec_nv_q, 4'b0000};
    end
  end

  // Datapath registers, each loaded in the state that produces it
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          a_q   <= bus.opa;
          b_q   <= bus.opb;
          sub_q <= bus.op_sub;
          rm_q  <= bus.rm;
        end
        S_ALIGN: begin
          s1_q       <= s_hi;
          s2_q       <= s_lo;
          exp_q      <= {2'b00, e_hi};
          m1_q       <= hi_field;
          m2_q       <= m2_al;
          stk_q      <= stk_al;
          spec_q     <= spec;
          spec_nv_q  <= spec_nv;
          spec_val_q <= spec_val;
        end
        S_ADD: begin
          sum_q <= sum_c;
          sgn_q <= sgn_c;
        end
        S_NORM: begin
          nm_q   <= nm_c;
          nexp_q <= nexp_c;
        end
        S_ROUND: if (!bus.flush) begin
          res_q   <= res_c;
          flags_q <= flags_c;
        end
        default: ;
      endcase
    end
  end

  // Result must rise exactly five cycles after the accepting cycle
  generate
    if (LATENCY_CHECK) begin : g_lat_chk
      a_latency: assert property (@(posedge clk) disable iff (reset)
        $rose(bus.out_valid) |-> $past(accept, 5));
    end
  endgenerate
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: hand-computed FP32 vectors, latency,
// reset/flush kill, and output hold under back-pressure.
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_addsub_seq_if bus();

  fp_addsub_seq #(.MANT_W(48), .LATENCY_CHECK(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after the accept edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [2:0] r);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.opa      = a;
    bus.opb      = b;
    bus.op_sub   = sub;
    bus.rm       = r;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles after accept until out_valid, bounded
  task automatic wait_out(output int n);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [2:0] r,
                        input logic [31:0] eres, input logic [4:0] eflg);
    int n;
    logic [36:0] e;
    exp_q.push_back({eflg, eres});
    start_op(a, b, sub, r);
    wait_out(n);
    check({tag, "_lat"}, 32'(n), 32'd5);
    e = exp_q.pop_front();
    check({tag, "_res"}, bus.result, e[31:0]);
    check({tag, "_flg"}, 32'(bus.fflags), 32'(e[36:32]));
    @(negedge clk);
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic watch_no_output(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    logic [36:0] e;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.rm        = 3'b000;
    bus.opa       = '0;
    bus.opb       = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_result", bus.result, 32'd0);
    check("rst_fflags", 32'(bus.fflags), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);

    // Reset while the operation sits in ADD
    start_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    watch_no_output("midrst_no_stale", 10);

    run_op("one_plus_one",  32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000, 32'h4000_0000, 5'b00000);
    run_op("one_minus_rne", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 3'b000, 32'h0000_0000, 5'b00000);
    run_op("one_minus_rdn", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 3'b010, 32'h8000_0000, 5'b00000);
    run_op("tiny_rne",      32'h3F80_0000, 32'h3380_0000, 1'b0, 3'b000, 32'h3F80_0000, 5'b00001);
    run_op("tiny_rup",      32'h3F80_0000, 32'h3380_0000, 1'b0, 3'b011, 32'h3F80_0001, 5'b00001);
    run_op("ovf_rne",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 3'b000, 32'h7F80_0000, 5'b00101);
    run_op("ovf_rtz",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 3'b001, 32'h7F7F_FFFF, 5'b00101);
    run_op("norm_left",     32'h3FC0_0000, 32'h3F80_0000, 1'b1, 3'b000, 32'h3F00_0000, 5'b00000);
    run_op("plus_negzero",  32'h3F80_0000, 32'h8000_0000, 1'b0, 3'b000, 32'h3F80_0000, 5'b00000);
    run_op("zero_zero_rdn", 32'h0000_0000, 32'h8000_0000, 1'b0, 3'b010, 32'h8000_0000, 5'b00000);
    run_op("snan_in",       32'h7F80_0001, 32'h3F80_0000, 1'b0, 3'b000, 32'h7FC0_0000, 5'b10000);
    run_op("inf_plus_fin",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 3'b000, 32'h7F80_0000, 5'b00000);

    // inf - inf under back-pressure: result must hold for 10 cycles
    bus.out_ready = 1'b0;
    exp_q.push_back({5'b10000, 32'h7FC0_0000});
    start_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'b000);
    wait_out(n);
    check("infinf_lat", 32'(n), 32'd5);
    e = exp_q.pop_front();
    check("infinf_res", bus.result, e[31:0]);
    check("infinf_flg", 32'(bus.fflags), 32'(e[36:32]));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.result !== e[31:0] || bus.fflags !== e[36:32]) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_rdy", 32'(bus.in_ready), 32'd1);

    // Flush while the operation sits in NORM
    start_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_state", 32'(bus.state_dbg), 32'd0);
    watch_no_output("flush_no_output", 8);

    run_op("after_flush", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000, 32'h4000_0000, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Multi-cycle sequencer for the FP32 add/sub path of the rv32imf FPU. It accepts one FADD.S/FSUB.S operation through a valid/ready handshake and registers the operands. It then steps the mantissa datapath through align, add, normalize and round states, and returns a rounded IEEE-754 result with fflags. One operation is in flight at a time. The FPU issue logic stalls on in_ready=0.

Parameters:
MANT_W, 48, width of the aligned mantissa working field: 24-bit significand plus 24 guard/extension bits.
LATENCY_CHECK, 1, when 1, the simulation-only assertion that out_valid rises exactly 5 cycles after accept is enabled.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  high only in IDLE
op_sub  input  1  1 = a - b, 0 = a + b
rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes handled as RNE
opa  input  32  FP32 operand a
opb  input  32  FP32 operand b
flush  input  1  kill the in-flight operation (pipeline flush)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  32  FP32 result
fflags  output  5  {NV,DZ,OF,UF,NX}; DZ is always 0
busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE; out_valid=0; result=0; fflags=0; busy=0; in_ready=1 on the first cycle after reset. Reset mid-operation discards the operation with no output.
- States:
  - IDLE -> ALIGN on in_valid&in_ready. Operands, op_sub and rm are latched; effective sign_b = opb[31]^op_sub.
  - ALIGN -> ADD. Exponents are compared and the swap puts the larger magnitude in operand 1. The smaller significand is right-shifted by the exponent difference inside a 48-bit field. A shift >= 48 collapses the field to 0 and sets a sticky flag if the shifted-out bits were nonzero. Subnormal inputs use exponent 1 and hidden bit 0. Special cases are classified here.
  - ADD -> NORM. Same effective sign: add in 49 bits. Different signs: larger minus smaller. Result sign = sign of the larger magnitude. An exact-zero difference gives sign +0, except under RDN, which gives -0.
  - NORM -> ROUND. On carry: shift right 1, exp+1, and OR the lost bit into sticky. Otherwise shift left by the leading-zero count, limited so that exp does not drop below 1 (subnormal result).
  - ROUND -> DONE. Round on guard/round/sticky per rm. A mantissa carry from rounding increments exp. exp >= 255 gives overflow: +/-inf for RNE/RMM/directed-toward; max finite (0x7F7FFFFF / 0xFF7FFFFF) for RTZ and directed-away.
  - DONE: out_valid=1. result/fflags are held stable until out_ready; the handshake returns to IDLE. out_valid&out_ready with in_valid in the same cycle does not accept the new request; accept happens the next cycle.
- Fixed latency: accept at cycle T gives out_valid=1 at T+5, including for special cases. Throughput is at most one operation per 6 cycles at out_ready=1.
- Special cases (override the datapath result in ROUND):
  - Any NaN input gives 0x7FC00000. NV is set if either input is an sNaN.
  - inf + (-inf) effective gives 0x7FC00000 with NV.
  - inf op finite gives that inf.
  - x + 0 gives x exactly; (+0)+(-0) gives +0 (RDN: -0).
- Flags: OF implies NX. UF is set when the result is tiny after rounding and inexact. NX is set when guard|round|sticky != 0 or on overflow.
- flush: in ALIGN/ADD/NORM/ROUND, goes to IDLE next cycle with no out_valid. In DONE, flush is ignored. In IDLE, flush is a no-op. reset beats flush; flush beats in_valid in the same cycle.
- in_ready is combinational from state only and does not depend on in_valid.

Test Plan:
1. reset for 2 cycles mid-ADD -> out_valid=0, busy=0, in_ready=1 the cycle after reset deasserts; no stale output is produced.
2. opa=0x3F800000, opb=0x3F800000, op_sub=0, rm=RNE, out_ready=1 -> out_valid exactly 5 cycles after accept; result=0x40000000, fflags=0; in_ready=1 on the next cycle.
3. opa=0x3F800000, opb=0x3F800000, op_sub=1 -> result=0x00000000 with rm=RNE; with rm=RDN -> result=0x80000000; fflags=0 in both cases.
4. opa=0x3F800000, opb=0x33800000 (2^-24), op_sub=0 -> RNE gives 0x3F800000 with NX=1; RUP gives 0x3F800001 with NX=1.
5. opa=0x7F7FFFFF, opb=0x7F7FFFFF, op_sub=0 -> RNE gives 0x7F800000 with fflags=00101; RTZ gives 0x7F7FFFFF with fflags=00101.
6. opa=0x7F800000, opb=0x7F800000, op_sub=1 -> result 0x7FC00000, fflags=10000. Also: out_ready=0 for 10 cycles holds result stable. Also: flush asserted in NORM produces no out_valid and returns in_ready=1 next cycle.
